// File: rtl/ad_cache_sched_if.sv
// ad_cache scheduler bus: channel switch/rdata/rd, USB FIFO write side,
// overrun flags and status. master = environment, slave = scheduler.
interface ad_cache_sched_if #(
  parameter int N_CH = 4
);
  logic                 en;
  logic [N_CH-1:0]      switch;
  logic [16*N_CH-1:0]   rdata;
  logic [N_CH-1:0]      rd;
  logic                 usb_afull;
  logic                 usb_wr;
  logic [15:0]          usb_wdata;
  logic                 ovr_clr;
  logic [N_CH-1:0]      ovr;
  logic                 busy;
  logic [3:0]           cur_ch;

  modport master (
    output en, switch, rdata, usb_afull, ovr_clr,
    input  rd, usb_wr, usb_wdata, ovr, busy, cur_ch
  );

  modport slave (
    input  en, switch, rdata, usb_afull, ovr_clr,
    output rd, usb_wr, usb_wdata, ovr, busy, cur_ch
  );
endinterface

// File: rtl/ad_cache_sched.sv
// Round-robin drain scheduler: ad_cache half-buffers -> USB FIFO.
// Ports: clk, rst (sync, high), bus (slave modport of ad_cache_sched_if).
module ad_cache_sched #(
  parameter int          N_CH      = 4,
  parameter int          BURST_LEN = 1536,
  parameter int          RD_LAT    = 2,
  parameter logic [11:0] HDR_TAG   = 12'hA5A
) (
  input  logic            clk,
  input  logic            rst,
  ad_cache_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, HEADER, BURST, DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   sw_prev_q;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   ovr_q, ovr_d;
  logic [N_CH-1:0]   tog, own, gmask, ovr_set;
  logic [3:0]        rr_q, rr_d;
  logic [3:0]        cur_q, cur_d;
  logic [3:0]        gnt, g_hi, g_lo;
  logic              found, f_hi, fire;
  logic              busy_q, busy_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              hdr_q, hdr_d, rd_any;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [15:0]       wdata_q, wdata_d, rsel;

  // Round-robin: lowest pending index >= rr_q, else lowest overall.
  always_comb begin
    g_hi = '0;
    g_lo = '0;
    f_hi = 1'b0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        g_lo = 4'(i);
        found = 1'b1;
        if (4'(i) >= rr_q) begin
          g_hi = 4'(i);
          f_hi = 1'b1;
        end
      end
    end
    gnt = f_hi ? g_hi : g_lo;
  end

  assign fire = (state_q == IDLE) && bus.en && found;

  // Toggle bookkeeping; a new overrun beats a same-cycle clear.
  always_comb begin
    tog = bus.switch ^ sw_prev_q;
    own = '0;
    gmask = '0;
    for (int i = 0; i < N_CH; i++) begin
      own[i] = busy_q && (cur_q == 4'(i));
      gmask[i] = fire && (gnt == 4'(i));
    end
    if (bus.en) begin
      ovr_set = tog & (pend_q | own);
      pend_d = (pend_q & ~gmask) | tog;
    end else begin
      ovr_set = '0;
      pend_d = '0;
    end
    ovr_d = (bus.ovr_clr ? '0 : ovr_q) | ovr_set;
  end

  // Next-state; cnt_q counts strobes in BURST, cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    busy_d = busy_q;
    rr_d = rr_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          cur_d = gnt;
          busy_d = 1'b1;
          rr_d = (gnt == 4'(N_CH - 1)) ? 4'd0 : gnt + 4'd1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (!bus.usb_afull) state_d = BURST;
      end
      BURST: begin
        if (!bus.usb_afull) begin
          if (cnt_q == 16'(BURST_LEN - 1)) begin
            cnt_d = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 16'(RD_LAT - 1)) begin
          cnt_d = '0;
          busy_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobes, header request, write pipeline.
  always_comb begin
    rd_any = (state_q == BURST) && !bus.usb_afull;
    hdr_d = (state_q == HEADER) && !bus.usb_afull;
    bus.rd = '0;
    rsel = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.rd[i] = rd_any && (cur_q == 4'(i));
      if (cur_q == 4'(i)) rsel = bus.rdata[16*i +: 16];
    end
    pipe_d = (pipe_q << 1) | RD_LAT'(rd_any);
    // Channel word is captured one cycle before its write shows,
    // the output register supplying the last latency cycle.
    if (hdr_d) begin
      wdata_d = {HDR_TAG, cur_q};
    end else if (pipe_d[RD_LAT-1]) begin
      wdata_d = rsel;
    end else begin
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sw_prev_q <= bus.switch;
      pend_q <= '0;
      ovr_q <= '0;
      rr_q <= '0;
      cur_q <= '0;
      busy_q <= 1'b0;
      cnt_q <= '0;
      hdr_q <= 1'b0;
      pipe_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sw_prev_q <= bus.switch;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      rr_q <= rr_d;
      cur_q <= cur_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      pipe_q <= pipe_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.usb_wr = hdr_q | pipe_q[RD_LAT-1];
  assign bus.usb_wdata = wdata_q;
  assign bus.ovr = ovr_q;
  assign bus.busy = busy_q;
  assign bus.cur_ch = cur_q;

endmodule

// File: tb/tb_ad_cache_sched.sv
// Scoreboard bench for ad_cache_sched (N_CH=4, BURST_LEN=6, RD_LAT=2).
// A one-stage ad_cache read model feeds rdata.
module tb_ad_cache_sched;
  localparam int N = 4;
  localparam int BL = 6;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ad_cache_sched_if #(.N_CH(N)) bus ();

  ad_cache_sched #(
    .N_CH(N), .BURST_LEN(BL), .RD_LAT(RL), .HDR_TAG(12'hA5A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rd = 0;
  int last_wr = 0;
  int fall = 0;
  int n;
  logic [15:0] q[$];
  int rd_cyc[$];
  logic busy_p = 1'b0;
  logic [3:0] cur_exp = '0;
  logic [15:0] mon_w;
  logic [15:0] rcnt[N];
  logic [15:0] rword[N];
  logic [15:0] seq[N];

  function automatic logic [15:0] base(int ch);
    case (ch)
      0: return 16'h1000;
      1: return 16'h2000;
      2: return 16'h0000;
      default: return 16'h3000;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ad_cache read model: word appears the cycle after its strobe.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        rcnt[i] <= '0;
        rword[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.rd[i]) begin
          rcnt[i] <= rcnt[i] + 16'd1;
          rword[i] <= base(i) + rcnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < N; i++) bus.rdata[16*i +: 16] = rword[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.usb_wr === 1'b1) begin
      last_wr = cyc;
      if (q.size() == 0) begin
        chk("spurious_wr", 1, 0);
      end else begin
        mon_w = q.pop_front();
        if (mon_w[15:4] == 12'hA5A) cur_exp = mon_w[3:0];
        chk("wdata", bus.usb_wdata, mon_w);
      end
    end
    if (bus.rd !== '0) begin
      rd_cyc.push_back(cyc);
      last_rd = cyc;
      chk("rd_sel", bus.rd, 4'b0001 << cur_exp);
    end
    if (busy_p && !bus.busy) fall = cyc;
    busy_p = bus.busy;
  end

  task automatic push_words(int ch, int cnt);
    q.push_back({12'hA5A, 4'(ch)});
    for (int k = 0; k < cnt; k++) begin
      seq[ch] = seq[ch] + 16'd1;
      q.push_back(base(ch) + seq[ch]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(logic [3:0] m);
    tick();
    bus.switch = bus.switch ^ m;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = '0;
  endtask

  task automatic wait_busy(string tag);
    int k = 0;
    @(negedge clk);
    #1;
    while (!bus.busy && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, k < 50, 1);
  endtask

  task automatic wait_done(string tag);
    int k = 0;
    repeat (3) @(negedge clk);
    #1;
    while ((q.size() != 0 || bus.busy) && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, k < 500, 1);
  endtask

  task automatic wait_rds(string tag, int cnt);
    int k = 0;
    while (rd_cyc.size() < cnt && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, k < 50, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.switch = '0;
    bus.usb_afull = 1'b0;
    bus.ovr_clr = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", bus.rd, 0);
    chk("rst_wr", bus.usb_wr, 0);
    chk("rst_wdata", bus.usb_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cur", bus.cur_ch, 0);
    chk("rst_ovr", bus.ovr, 0);
    tick();
    rst = 1'b0;

    // single channel burst
    bus.en = 1'b1;
    push_words(2, BL);
    rd_cyc.delete();
    toggle(4'b0100);
    wait_done("ch2_done");
    chk("ch2_rd_count", rd_cyc.size(), BL);
    chk("ch2_wr_lat", last_wr - last_rd, RL);
    chk("ch2_busy_fall", fall - last_rd, RL + 1);
    chk("ch2_cur", bus.cur_ch, 2);

    // round robin
    do_reset();
    push_words(0, BL);
    push_words(3, BL);
    toggle(4'b1001);
    wait_done("rr_a");
    push_words(0, BL);
    toggle(4'b0001);
    wait_done("rr_b");
    push_words(3, BL);
    push_words(0, BL);
    toggle(4'b1001);
    wait_done("rr_c");
    chk("rr_c_cur", bus.cur_ch, 0);

    // afull stall mid-burst
    push_words(1, BL);
    rd_cyc.delete();
    toggle(4'b0010);
    wait_rds("afull_wait", 2);
    tick();
    bus.usb_afull = 1'b1;
    repeat (3) tick();
    bus.usb_afull = 1'b0;
    wait_done("afull_done");
    chk("afull_rd_count", rd_cyc.size(), BL);
    chk("afull_gap", rd_cyc[2] - rd_cyc[1], 4);

    // overrun set / clear / set-wins
    push_words(0, BL);
    push_words(1, BL);
    toggle(4'b0001);
    wait_busy("ovr_busy");
    toggle(4'b0010);
    toggle(4'b0010);
    wait_done("ovr_a");
    chk("ovr_set", bus.ovr, 4'b0010);
    tick();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", bus.ovr, 0);
    push_words(1, BL);
    push_words(1, BL);
    toggle(4'b0010);
    wait_busy("ovr_busy2");
    chk("ovr_busy2_ch", bus.cur_ch, 1);
    tick();
    bus.switch = bus.switch ^ 4'b0010;
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", bus.ovr, 4'b0010);
    wait_done("ovr_b");
    tick();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;

    // en falls mid-grant: ch3 finishes, pending ch0 dropped
    push_words(3, BL);
    toggle(4'b1001);
    wait_busy("enfall_busy");
    tick();
    bus.en = 1'b0;
    wait_done("enfall_done");
    chk("enfall_cur", bus.cur_ch, 3);
    bus.en = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("enfall_nogrant", bus.busy, 0);

    // reset after third strobe
    push_words(2, 2);
    rd_cyc.delete();
    toggle(4'b0100);
    wait_rds("rstb_wait", 3);
    tick();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstb_rd", bus.rd, 0);
    chk("rstb_wr", bus.usb_wr, 0);
    chk("rstb_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = '0;
    rd_cyc.delete();
    repeat (15) @(negedge clk);
    #1;
    chk("rstb_no_rd", rd_cyc.size(), 0);
    chk("rstb_q", q.size(), 0);
    chk("rstb_cur", bus.cur_ch, 0);
    chk("rstb_idle", bus.busy, 0);

    // disabled: toggles ignored
    bus.en = 1'b0;
    rd_cyc.delete();
    for (int k = 0; k < 3; k++) toggle(4'b1111);
    toggle(4'b0101);
    repeat (20) @(negedge clk);
    #1;
    chk("en0_rd", rd_cyc.size(), 0);
    chk("en0_q", q.size(), 0);
    chk("en0_ovr", bus.ovr, 0);
    chk("en0_busy", bus.busy, 0);
    bus.en = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("en0_no_pend", bus.busy, 0);
    chk("en0_rd2", rd_cyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
